jtag_sequencer: RTL and testbench

JTAG_SEQUENCER -- requirements
Module: jtag_sequencer

---
 rtl/jtag_sequencer.sv | 178 +++++++++++++++++
 tb/tb_jtag_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_sequencer.sv
// Purpose : turns host commands (TAP reset, IR load, DR scan, NOP) into TMS/TDI scan sequences and captures TDO.
// Latency : TAP reset 6, IR load 4+IR_LEN+2, DR scan 3+L+2, NOP 1 busy cycles; done pulses on the following IDLE cycle.
// Backpr. : cmd_ready is high only in IDLE; cmd_valid presented while busy is ignored, not queued.
//
// Ports: TCK/TRST scan clock and async active-high reset; cmd_valid/cmd_ready/cmd_op/cmd_len/cmd_data host
// command handshake; TMS/TDI registered TAP drive, TDO TAP return; rsp_data captured TDO bits (LSB first);
// done one-cycle completion pulse; busy = !cmd_ready.
module jtag_sequencer #(
    parameter int IR_LEN = 2,
    parameter int DR_MAX = 16
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              done,
    output logic              busy
);

    localparam int LMAX = (DR_MAX > IR_LEN) ? DR_MAX : IR_LEN;
    localparam int CW   = $clog2(LMAX + 8) + 1;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_DR  = 2'b10;

    typedef enum logic [3:0] {
        IDLE, TLR, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RETURN
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     len_q;
    logic [DR_MAX-1:0] data_q;
    logic              is_ir;
    logic              active;   // a host command (not the auto-reset) is in flight
    logic [CW-1:0]     dr_len;

    // Effective DR length: 0 scans one bit, oversize requests saturate.
    always_comb begin
        dr_len = CW'(cmd_len);
        if (cmd_len == 5'd0) begin
            dr_len = CW'(1);
        end else if (int'(cmd_len) > DR_MAX) begin
            dr_len = CW'(DR_MAX);
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;

    // TMS/TDI are registered alongside the next state so they are valid for
    // the whole cycle the FSM spends in that state. CAPTURE spans two cycles:
    // the first walks the TAP Select->Capture, the second Capture->Shift, so
    // TDI bit 0 lines up with the first cycle the TAP sits in Shift.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state    <= TLR;
            cnt      <= '0;
            len_q    <= '0;
            data_q   <= '0;
            is_ir    <= 1'b0;
            active   <= 1'b0;
            TMS      <= 1'b1;
            TDI      <= 1'b0;
            done     <= 1'b0;
            rsp_data <= '0;
        end else begin
            done <= 1'b0;
            TDI  <= 1'b0;
            case (state)
                IDLE: begin
                    TMS <= 1'b0;
                    if (cmd_valid) begin
                        active   <= 1'b1;
                        rsp_data <= '0;
                        data_q   <= cmd_data;
                        cnt      <= '0;
                        case (cmd_op)
                            OP_RST: begin
                                state <= TLR;
                                TMS   <= 1'b1;
                            end
                            OP_IR: begin
                                state <= SEL_DR;
                                TMS   <= 1'b1;
                                is_ir <= 1'b1;
                                len_q <= CW'(IR_LEN);
                            end
                            OP_DR: begin
                                state <= SEL_DR;
                                TMS   <= 1'b1;
                                is_ir <= 1'b0;
                                len_q <= dr_len;
                            end
                            default: begin
                                state <= RETURN;
                                TMS   <= 1'b0;
                            end
                        endcase
                    end
                end
                TLR: begin
                    if (cnt == CW'(4)) begin
                        state <= RETURN;
                        cnt   <= '0;
                        TMS   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        TMS <= 1'b1;
                    end
                end
                SEL_DR: begin
                    cnt <= '0;
                    if (is_ir) begin
                        state <= SEL_IR;
                        TMS   <= 1'b1;
                    end else begin
                        state <= CAPTURE;
                        TMS   <= 1'b0;
                    end
                end
                SEL_IR: begin
                    state <= CAPTURE;
                    cnt   <= '0;
                    TMS   <= 1'b0;
                end
                CAPTURE: begin
                    if (cnt == '0) begin
                        cnt <= CW'(1);
                        TMS <= 1'b0;
                    end else begin
                        state <= SHIFT;
                        cnt   <= '0;
                        TMS   <= (len_q == CW'(1));
                        TDI   <= data_q[0];
                    end
                end
                SHIFT: begin
                    rsp_data[cnt] <= TDO;
                    if (cnt == len_q - CW'(1)) begin
                        state <= EXIT1;
                        cnt   <= '0;
                        TMS   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                        TMS <= (cnt + CW'(2) == len_q);
                        TDI <= data_q[cnt + CW'(1)];
                    end
                end
                EXIT1: begin
                    state <= UPDATE;
                    TMS   <= 1'b0;
                end
                UPDATE, RETURN: begin
                    state  <= IDLE;
                    TMS    <= 1'b0;
                    done   <= active;
                    active <= 1'b0;
                end
                default: begin
                    state  <= TLR;
                    cnt    <= '0;
                    TMS    <= 1'b1;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_sequencer.sv
module tb_jtag_sequencer;

    localparam int IRL = 2;
    localparam int DRM = 16;

    logic           TCK, TRST, cmd_valid, cmd_ready, TMS, TDI, TDO, done, busy;
    logic [1:0]     cmd_op;
    logic [4:0]     cmd_len;
    logic [DRM-1:0] cmd_data, rsp_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic tms;
        logic tdi;
        logic tdo;
    } exp_t;

    exp_t           exp_q[$];
    logic [DRM-1:0] rsp_q[$];

    jtag_sequencer #(.IR_LEN(IRL), .DR_MAX(DRM)) dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .rsp_data (rsp_data),
        .done     (done),
        .busy     (busy)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // Reference IEEE 1149.1 TAP controller with a 2-bit IR, driven by the DUT.
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SDS, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
        T_SIS, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_t;

    tap_t           tap_st;
    logic [IRL-1:0] ir_sh, ir_inst;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            tap_st  <= T_TLR;
            ir_sh   <= '0;
            ir_inst <= '0;
        end else begin
            case (tap_st)
                T_TLR:  tap_st <= TMS ? T_TLR  : T_RTI;
                T_RTI:  tap_st <= TMS ? T_SDS  : T_RTI;
                T_SDS:  tap_st <= TMS ? T_SIS  : T_CDR;
                T_CDR:  tap_st <= TMS ? T_E1DR : T_SHDR;
                T_SHDR: tap_st <= TMS ? T_E1DR : T_SHDR;
                T_E1DR: tap_st <= TMS ? T_UDR  : T_PDR;
                T_PDR:  tap_st <= TMS ? T_E2DR : T_PDR;
                T_E2DR: tap_st <= TMS ? T_UDR  : T_SHDR;
                T_UDR:  tap_st <= TMS ? T_SDS  : T_RTI;
                T_SIS:  tap_st <= TMS ? T_TLR  : T_CIR;
                T_CIR:  tap_st <= TMS ? T_E1IR : T_SHIR;
                T_SHIR: tap_st <= TMS ? T_E1IR : T_SHIR;
                T_E1IR: tap_st <= TMS ? T_UIR  : T_PIR;
                T_PIR:  tap_st <= TMS ? T_E2IR : T_PIR;
                T_E2IR: tap_st <= TMS ? T_UIR  : T_SHIR;
                default: tap_st <= TMS ? T_SDS : T_RTI;
            endcase
            if (tap_st == T_SHIR) ir_sh <= {TDI, ir_sh[IRL-1:1]};
            if (tap_st == T_UIR)  ir_inst <= ir_sh;
            if (tap_st == T_TLR)  ir_inst <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic tms, input logic tdi, input logic tdo);
        exp_t e;
        e.tms = tms;
        e.tdi = tdi;
        e.tdo = tdo;
        exp_q.push_back(e);
    endfunction

    // Present a command in an IDLE cycle, record its expected per-cycle TAP
    // drive and final rsp_data, then scramble the inputs after acceptance.
    task automatic start_cmd(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data,
                             input logic [15:0] tdo_pat, input bit in_done);
        int L;
        logic [DRM-1:0] r;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge TCK);
        chk("accept_ready", cmd_ready, 1);
        chk("done_at_accept", done, in_done);
        if (in_done) chk("rsp_prev", rsp_data, rsp_q.pop_front());
        L = (len == 0) ? 1 : ((int'(len) > DRM) ? DRM : int'(len));
        r = '0;
        case (op)
            2'b00: begin
                repeat (5) push(1'b1, 1'b0, 1'b0);
                push(1'b0, 1'b0, 1'b0);
            end
            2'b11: push(1'b0, 1'b0, 1'b0);
            default: begin
                push(1'b1, 1'b0, 1'b0);
                if (op == 2'b01) begin
                    L = IRL;
                    push(1'b1, 1'b0, 1'b0);
                end
                push(1'b0, 1'b0, 1'b0);
                push(1'b0, 1'b0, 1'b0);
                for (int i = 0; i < L; i++) begin
                    push(i == L - 1, data[i], tdo_pat[i]);
                    r[i] = tdo_pat[i];
                end
                push(1'b1, 1'b0, 1'b0);
                push(1'b0, 1'b0, 1'b0);
            end
        endcase
        rsp_q.push_back(r);
        @(posedge TCK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 5'd3;
        cmd_data  = ~data;
    endtask

    task automatic step_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard_underrun observed=empty expected=entry");
                break;
            end
            e   = exp_q.pop_front();
            TDO = e.tdo;
            @(negedge TCK);
            chk("tms", TMS, e.tms);
            chk("tdi", TDI, e.tdi);
            chk("busy", busy, 1);
            chk("done_while_busy", done, 0);
            @(posedge TCK);
            #1;
        end
        TDO = 1'b0;
    endtask

    task automatic finish_check();
        logic [DRM-1:0] r;
        r = rsp_q.pop_front();
        @(negedge TCK);
        chk("done_pulse", done, 1);
        chk("busy_idle", busy, 0);
        chk("ready_idle", cmd_ready, 1);
        chk("tms_idle", TMS, 0);
        chk("tdi_idle", TDI, 0);
        chk("rsp_data", rsp_data, r);
        chk("tap_in_rti", tap_st, T_RTI);
        @(posedge TCK);
        #1;
        @(negedge TCK);
        chk("done_one_cycle", done, 0);
        chk("rsp_hold", rsp_data, r);
        @(posedge TCK);
        #1;
    endtask

    task automatic reset_release();
        TRST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge TCK);
            chk("rst_seq_tms", TMS, (k < 5) ? 1 : 0);
            chk("rst_seq_tdi", TDI, 0);
            chk("rst_seq_busy", busy, 1);
            chk("rst_seq_done", done, 0);
            @(posedge TCK);
            #1;
        end
        @(negedge TCK);
        chk("rst_ready_7th", cmd_ready, 1);
        chk("rst_no_done", done, 0);
        chk("rst_tap_rti", tap_st, T_RTI);
        @(posedge TCK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        TRST      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 5'd0;
        cmd_data  = '0;
        TDO       = 1'b0;

        // Values held during reset.
        repeat (2) @(posedge TCK);
        #1;
        @(negedge TCK);
        chk("rst_tms", TMS, 1);
        chk("rst_tdi", TDI, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_rsp", rsp_data, 0);
        @(posedge TCK);
        #1;
        reset_release();

        // TAP reset command.
        start_cmd(2'b00, 5'd0, 16'h0000, 16'h0000, 1'b0);
        step_cycles(exp_q.size());
        finish_check();

        // IR load 0x0003 -> IR captures 2'b11.
        start_cmd(2'b01, 5'd9, 16'h0003, 16'h0001, 1'b0);
        step_cycles(exp_q.size());
        finish_check();
        chk("ir_inst_11", ir_inst, 2'b11);

        // DR scan 8 bits, 0xA5 out, 0x3C in; cmd_valid held while busy must be ignored.
        start_cmd(2'b10, 5'd8, 16'h00A5, 16'h003C, 1'b0);
        cmd_valid = 1'b1;
        step_cycles(exp_q.size() - 1);
        cmd_valid = 1'b0;
        step_cycles(1);
        finish_check();

        // cmd_len = 0 scans one bit; upper rsp bits stay 0.
        start_cmd(2'b10, 5'd0, 16'hFFFF, 16'hFFFF, 1'b0);
        step_cycles(exp_q.size());
        finish_check();

        // cmd_len = 20 saturates to 16.
        start_cmd(2'b10, 5'd20, 16'h1234, 16'hBEEF, 1'b0);
        step_cycles(exp_q.size());
        finish_check();

        // NOP alone.
        start_cmd(2'b11, 5'd0, 16'h0000, 16'h0000, 1'b0);
        step_cycles(exp_q.size());
        finish_check();

        // IR load, then a NOP accepted in its done cycle with no gap.
        start_cmd(2'b01, 5'd0, 16'h0001, 16'h0002, 1'b0);
        step_cycles(exp_q.size());
        start_cmd(2'b11, 5'd0, 16'h0000, 16'h0000, 1'b1);
        chk("ir_inst_01", ir_inst, 2'b01);
        step_cycles(exp_q.size());
        finish_check();

        // TRST during the 4th SHIFT cycle of a 16-bit scan.
        start_cmd(2'b10, 5'd16, 16'h5555, 16'hFFFF, 1'b0);
        step_cycles(6);
        TDO = exp_q[0].tdo;
        #2;
        chk("pre_abort_rsp", rsp_data, 16'h0007);
        TRST = 1'b1;
        #1;
        chk("abort_tms", TMS, 1);
        chk("abort_tdi", TDI, 0);
        chk("abort_rsp", rsp_data, 0);
        chk("abort_busy", busy, 1);
        chk("abort_done", done, 0);
        exp_q.delete();
        rsp_q.delete();
        TDO = 1'b0;
        repeat (2) begin
            @(negedge TCK);
            chk("abort_hold_done", done, 0);
            chk("abort_hold_tms", TMS, 1);
        end
        @(posedge TCK);
        #1;
        reset_release();

        // Normal operation after the abort.
        start_cmd(2'b10, 5'd4, 16'h0005, 16'h000A, 1'b0);
        step_cycles(exp_q.size());
        finish_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
